// File: rtl/lakespec_pkg.sv
// Shared widths, configuration layout and the per-port configuration struct for lakespec.
package lakespec_pkg;

  localparam int unsigned DATA_WIDTH     = 16;
  localparam int unsigned ADDR_WIDTH     = 11;
  localparam int unsigned SCHED_WIDTH    = 16;
  localparam int unsigned MAX_DIM        = 6;
  localparam int unsigned DIM_WIDTH      = 3;
  localparam int unsigned PORT_CFG_WIDTH = 259;
  localparam int unsigned MEM_DEPTH      = 1 << ADDR_WIDTH;

  localparam int unsigned CFG_WIDTH      = 550;
  localparam int unsigned PORT0_BASE     = 0;
  localparam int unsigned PORT1_BASE     = PORT_CFG_WIDTH;
  localparam int unsigned RSVD_BASE      = 2 * PORT_CFG_WIDTH;

  localparam int unsigned OFF_ENABLE       = 0;
  localparam int unsigned OFF_DIM          = 1;
  localparam int unsigned OFF_EXTENT       = 4;
  localparam int unsigned OFF_ADDR_STRIDE  = 70;
  localparam int unsigned OFF_ADDR_OFFSET  = 136;
  localparam int unsigned OFF_SCHED_STRIDE = 147;
  localparam int unsigned OFF_SCHED_OFFSET = 243;

  // Field order (MSB first) reproduces the offsets above; element k of each array sits at k*width.
  typedef struct packed {
    logic [SCHED_WIDTH-1:0]                  sched_offset;
    logic [MAX_DIM-1:0][SCHED_WIDTH-1:0]     sched_stride;
    logic [ADDR_WIDTH-1:0]                   addr_offset;
    logic [MAX_DIM-1:0][ADDR_WIDTH-1:0]      addr_stride;
    logic [MAX_DIM-1:0][ADDR_WIDTH-1:0]      extent;
    logic [DIM_WIDTH-1:0]                    dim;
    logic                                    enable;
  } port_cfg_t;

  function automatic logic [DIM_WIDTH-1:0] eff_dim(input logic [DIM_WIDTH-1:0] dim);
    if (dim == '0) return DIM_WIDTH'(1);
    if (dim > DIM_WIDTH'(MAX_DIM)) return DIM_WIDTH'(MAX_DIM);
    return dim;
  endfunction

endpackage

// File: rtl/lakespec_port_ctrl.sv
// Per-port iteration domain: odometer indices, affine address/schedule generation, fire and done.
module lakespec_port_ctrl
  import lakespec_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  port_cfg_t              i_cfg,
  input  logic [SCHED_WIDTH-1:0] i_cycle,
  output logic                   o_fire,
  output logic [ADDR_WIDTH-1:0]  o_addr
);

  logic [MAX_DIM-1:0][ADDR_WIDTH-1:0] r_idx;
  logic [MAX_DIM-1:0][ADDR_WIDTH-1:0] w_idx_nxt;
  logic [MAX_DIM-1:0][ADDR_WIDTH-1:0] w_last;
  logic                               r_done;
  logic                               w_wrap;
  logic [DIM_WIDTH-1:0]               w_dim;
  logic [ADDR_WIDTH-1:0]              w_addr;
  logic [SCHED_WIDTH-1:0]             w_sched;

  assign w_dim = eff_dim(i_cfg.dim);

  // Inactive dimensions keep index 0, so they drop out of both sums.
  always_comb begin
    w_addr  = i_cfg.addr_offset;
    w_sched = i_cfg.sched_offset;
    w_last  = '0;
    for (int k = 0; k < MAX_DIM; k++) begin
      w_last[k] = (i_cfg.extent[k] == '0) ? '0 : i_cfg.extent[k] - ADDR_WIDTH'(1);
      w_addr    = w_addr + ADDR_WIDTH'(r_idx[k] * i_cfg.addr_stride[k]);
      w_sched   = w_sched + SCHED_WIDTH'(SCHED_WIDTH'(r_idx[k]) * i_cfg.sched_stride[k]);
    end
  end

  // Carry ripples from the innermost dimension; a carry out of the last active one ends the run.
  always_comb begin
    w_idx_nxt = r_idx;
    w_wrap    = 1'b1;
    for (int k = 0; k < MAX_DIM; k++) begin
      if ((k < int'(w_dim)) && w_wrap) begin
        if (r_idx[k] == w_last[k]) begin
          w_idx_nxt[k] = '0;
        end else begin
          w_idx_nxt[k] = r_idx[k] + ADDR_WIDTH'(1);
          w_wrap       = 1'b0;
        end
      end
    end
  end

  assign o_fire = i_cfg.enable & ~r_done & ~i_flush & (i_cycle == w_sched);
  assign o_addr = w_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_done <= 1'b0;
    end else if (i_flush) begin
      r_idx  <= '0;
      r_done <= 1'b0;
    end else if (o_fire) begin
      r_idx <= w_idx_nxt;
      if (w_wrap) r_done <= 1'b1;
    end
  end

endmodule

// File: rtl/lakespec.sv
// Statically scheduled 2048x16 buffer with one affine write port and one affine read port.
// Optional macro LAKESPEC_WR_BYPASS_EN forwards write data to a same-cycle, same-address read.
module lakespec
  import lakespec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [CFG_WIDTH-1:0]  config_memory_size_550,
  input  logic [DATA_WIDTH-1:0] port_0,
  output logic [DATA_WIDTH-1:0] port_1
);

  port_cfg_t               w_cfg_wr;
  port_cfg_t               w_cfg_rd;
  logic                    w_unused_rsvd;
  logic [SCHED_WIDTH-1:0]  r_cycle;
  logic [SCHED_WIDTH-1:0]  w_cycle;
  logic                    w_fire_wr;
  logic                    w_fire_rd;
  logic [ADDR_WIDTH-1:0]   w_addr_wr;
  logic [ADDR_WIDTH-1:0]   w_addr_rd;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic [DATA_WIDTH-1:0]   r_port1;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

  assign w_cfg_wr      = port_cfg_t'(config_memory_size_550[PORT0_BASE +: PORT_CFG_WIDTH]);
  assign w_cfg_rd      = port_cfg_t'(config_memory_size_550[PORT1_BASE +: PORT_CFG_WIDTH]);
  assign w_unused_rsvd = ^config_memory_size_550[CFG_WIDTH-1:RSVD_BASE];

  // Held at 0 during flush so the first cycle after flush is schedule cycle 0.
  assign w_cycle = flush ? '0 : r_cycle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle <= '0;
    end else if (flush) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + SCHED_WIDTH'(1);
    end
  end

  lakespec_port_ctrl u_wr_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_cfg   (w_cfg_wr),
    .i_cycle (w_cycle),
    .o_fire  (w_fire_wr),
    .o_addr  (w_addr_wr)
  );

  lakespec_port_ctrl u_rd_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_cfg   (w_cfg_rd),
    .i_cycle (w_cycle),
    .o_fire  (w_fire_rd),
    .o_addr  (w_addr_rd)
  );

  always_ff @(posedge clk) begin
    if (w_fire_wr) r_mem[w_addr_wr] <= port_0;
  end

`ifdef LAKESPEC_WR_BYPASS_EN
  assign w_rd_data = (w_fire_wr && (w_addr_wr == w_addr_rd)) ? port_0 : r_mem[w_addr_rd];
`else
  assign w_rd_data = r_mem[w_addr_rd];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port1 <= '0;
    end else if (w_fire_rd) begin
      r_port1 <= w_rd_data;
    end
  end

  assign port_1 = r_port1;

endmodule

// File: tb/tb_lakespec.sv
// Directed self-checking bench for lakespec: streaming, reset, flush, 2-D, collision, disabled port.
module tb_lakespec;
  import lakespec_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic [549:0] cfg;
  logic [15:0]  port_0;
  logic [15:0]  port_1;

  int n_checks;
  int n_errors;

  logic [15:0] din  [0:1023];
  logic [15:0] expv [0:1023];

  lakespec dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .flush                  (flush),
    .config_memory_size_550 (cfg),
    .port_0                 (port_0),
    .port_1                 (port_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic port_cfg_t mk_cfg(input logic en, input logic [2:0] dim,
                                       input logic [10:0] e0, input logic [10:0] e1,
                                       input logic [10:0] as0, input logic [10:0] as1,
                                       input logic [10:0] aoff,
                                       input logic [15:0] ss0, input logic [15:0] ss1,
                                       input logic [15:0] soff);
    port_cfg_t c;
    c                 = '0;
    c.enable          = en;
    c.dim             = dim;
    c.extent[0]       = e0;
    c.extent[1]       = e1;
    c.addr_stride[0]  = as0;
    c.addr_stride[1]  = as1;
    c.addr_offset     = aoff;
    c.sched_stride[0] = ss0;
    c.sched_stride[1] = ss1;
    c.sched_offset    = soff;
    return c;
  endfunction

  task automatic set_cfg(input port_cfg_t wr, input port_cfg_t rd);
    cfg = {32'hFFFF_FFFF, rd, wr};
  endtask

  // Leaves the bench 1 time unit into schedule cycle 0.
  task automatic apply_reset();
    rst_n  = 1'b0;
    flush  = 1'b0;
    port_0 = '0;
    @(posedge clk);
    #1;
    check("reset_port1", port_1, 16'h0000);
    rst_n = 1'b1;
  endtask

  // Data written at cycle c is read at c+1 and visible at c+2; cycles 0-1 still show 'pre'.
  task automatic fill(input int base, input int step, input logic [15:0] pre);
    for (int c = 0; c < 1024; c++) begin
      din[c]  = 16'(base + step * c);
      expv[c] = (c < 2) ? pre : 16'(base + step * (c - 2));
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      port_0 = din[c];
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, c), port_1, expv[c]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] coll_exp;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    port_0   = '0;

    // Streaming copy, 1000 words.
    set_cfg(mk_cfg(1'b1, 3'd1, 11'd1000, 11'd0, 11'd1, 11'd0, 11'd0, 16'd1, 16'd0, 16'd0),
            mk_cfg(1'b1, 3'd1, 11'd1000, 11'd0, 11'd1, 11'd0, 11'd0, 16'd1, 16'd0, 16'd1));
    apply_reset();
    fill(0, 2, 16'h0000);
    run(1002, "stream");

    // Reset pulse mid-run at schedule cycle 50.
    apply_reset();
    fill(0, 2, 16'h0000);
    run(50, "pre_rst");
    rst_n = 1'b0;
    #1;
    check("mid_reset_port1", port_1, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill(16'h0100, 1, 16'h0000);
    run(12, "post_rst");

    // Flush at cycle 20 for three cycles; port_1 holds the word read at cycle 19.
    apply_reset();
    fill(0, 2, 16'h0000);
    run(20, "pre_flush");
    flush  = 1'b1;
    port_0 = 16'hDEAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("flush_hold[%0d]", c), port_1, 16'd36);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    fill(16'h5000, 1, 16'd36);
    run(10, "post_flush");

    // 2-D write walks addresses 0..11; read is 1-D with dim 0 (acts as 1).
    set_cfg(mk_cfg(1'b1, 3'd2, 11'd4, 11'd3, 11'd1, 11'd4, 11'd0, 16'd1, 16'd4, 16'd0),
            mk_cfg(1'b1, 3'd0, 11'd12, 11'd0, 11'd1, 11'd0, 11'd0, 16'd1, 16'd0, 16'd1));
    apply_reset();
    fill(16'h0A00, 1, 16'h0000);
    expv[14] = 16'h0A0B;
    expv[15] = 16'h0A0B;
    run(16, "dim2");

    // Same-cycle collision at addr 5: old 0x1234, new 0xAAAA at cycle 3.
    set_cfg(mk_cfg(1'b1, 3'd1, 11'd2, 11'd0, 11'd0, 11'd0, 11'd5, 16'd3, 16'd0, 16'd0),
            mk_cfg(1'b1, 3'd1, 11'd1, 11'd0, 11'd0, 11'd0, 11'd5, 16'd0, 16'd0, 16'd3));
    apply_reset();
`ifdef LAKESPEC_WR_BYPASS_EN
    coll_exp = 16'hAAAA;
`else
    coll_exp = 16'h1234;
`endif
    for (int c = 0; c < 8; c++) begin
      din[c]  = 16'hFFFF;
      expv[c] = (c < 4) ? 16'h0000 : coll_exp;
    end
    din[0] = 16'h1234;
    din[3] = 16'hAAAA;
    run(8, "collide");

    // Read port disabled: port_1 never leaves its reset value.
    set_cfg(mk_cfg(1'b1, 3'd1, 11'd1000, 11'd0, 11'd1, 11'd0, 11'd0, 16'd1, 16'd0, 16'd0),
            mk_cfg(1'b0, 3'd1, 11'd1000, 11'd0, 11'd1, 11'd0, 11'd0, 16'd1, 16'd0, 16'd1));
    apply_reset();
    fill(0, 2, 16'h0000);
    for (int c = 0; c < 1024; c++) expv[c] = 16'h0000;
    run(1000, "disabled");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
